// File: rtl/spi_xfer.sv
// rtl/spi_xfer.sv - SPI mode-0 byte transfer engine with programmable SCK half-period
// One byte per START, MSB first; RDATA updates only when a transfer completes.
module spi_xfer #(
  parameter int unsigned DIVW = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            START,
  input  logic [7:0]      WDATA,
  input  logic [DIVW-1:0] DIV,
  input  logic            MISO,
  output logic            SCK,
  output logic            MOSI,
  output logic            BUSY,
  output logic            DONE,
  output logic [7:0]      RDATA
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  logic            armed_q, armed_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    // Blocks acceptance on the first edge after reset release.
    armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b1;
        if (START && armed_q) begin
          state_d = SHIFT;
          div_d   = DIV;
          cnt_d   = DIV;
          bit_d   = 4'd0;
          tx_d    = WDATA;
          rx_d    = 8'h00;
          mosi_d  = WDATA[7];
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], MISO};
          end else if (bit_q == 4'd7) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdata_d = rx_q;
            mosi_d  = 1'b1;
            bit_d   = 4'd0;
            cnt_d   = '0;
          end else begin
            bit_d  = bit_q + 4'd1;
            mosi_d = tx_q[6];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - DIVW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign SCK   = sck_q;
  assign MOSI  = mosi_q;
  assign BUSY  = (state_q == SHIFT);
  assign DONE  = done_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_spi_xfer.sv
// tb/tb_spi_xfer.sv - directed scoreboard bench for spi_xfer
module tb_spi_xfer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       START;
  logic [7:0] WDATA;
  logic [3:0] DIV;
  logic       MISO;
  logic       SCK, MOSI, BUSY, DONE;
  logic [7:0] RDATA;

  logic       loopback;
  logic       miso_tie;
  logic [7:0] sb[$];
  logic [7:0] last_rd;
  int         n_checks = 0;
  int         n_fail   = 0;

  assign MISO = loopback ? MOSI : miso_tie;

  spi_xfer #(.DIVW(4)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .WDATA(WDATA), .DIV(DIV),
    .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer at the current time (just after a negedge) and follows it to DONE.
  task automatic xfer(input logic [7:0] wd, input logic [3:0] dv, input bit loop,
                      input logic tie, input int poke_cyc, input logic poke_start,
                      input logic [7:0] poke_wd, input logic [3:0] poke_dv);
    int   dvi, cyc, runlen, pulses, bad_runs, bad_mosi, bad_rd, bad_busy, done_cyc, budget;
    logic prev_sck;
    logic [7:0] exp_rd;
    dvi = int'(dv);
    loopback = loop;
    miso_tie = tie;
    exp_rd = loop ? wd : {8{tie}};
    sb.push_back(exp_rd);
    START = 1'b1;
    WDATA = wd;
    DIV   = dv;
    @(negedge CLK);
    START = 1'b0;
    check("start_busy", BUSY, 1);
    check("start_sck", SCK, 0);
    check("start_mosi", MOSI, wd[7]);
    cyc = 0; runlen = 1; pulses = 0; bad_runs = 0; bad_mosi = 0; bad_rd = 0; bad_busy = 0;
    done_cyc = -1;
    budget = 16 * (dvi + 1) + 8;
    prev_sck = SCK;
    while (done_cyc < 0 && cyc < budget) begin
      if (cyc == poke_cyc) begin
        START = poke_start;
        WDATA = poke_wd;
        DIV   = poke_dv;
      end else if (cyc == poke_cyc + 1) begin
        START = 1'b0;
      end
      @(negedge CLK);
      cyc++;
      if (SCK !== prev_sck) begin
        if (runlen != dvi + 1) bad_runs++;
        runlen = 1;
        if (SCK === 1'b1) begin
          if (pulses < 8 && MOSI !== wd[7 - pulses]) bad_mosi++;
          pulses++;
        end
      end else begin
        runlen++;
      end
      prev_sck = SCK;
      if (DONE === 1'b1) begin
        done_cyc = cyc;
        check("done_sck", SCK, 0);
        check("done_busy", BUSY, 0);
        check("done_mosi", MOSI, 1);
      end else begin
        if (RDATA !== last_rd) bad_rd++;
        if (BUSY !== 1'b1) bad_busy++;
      end
    end
    check("done_latency", done_cyc, 16 * (dvi + 1));
    check("sck_pulses", pulses, 8);
    check("sck_run_len", bad_runs, 0);
    check("mosi_bits", bad_mosi, 0);
    check("rdata_stable", bad_rd, 0);
    check("busy_held", bad_busy, 0);
    if (sb.size() > 0) begin
      exp_rd = sb.pop_front();
      check("rdata", RDATA, exp_rd);
      last_rd = exp_rd;
    end
  endtask

  initial begin
    int stray;
    nRST = 1'b0; START = 1'b0; WDATA = 8'h00; DIV = 4'd0;
    loopback = 1'b1; miso_tie = 1'b0; last_rd = 8'h00;
    repeat (2) @(negedge CLK);
    check("rst_sck", SCK, 0);
    check("rst_mosi", MOSI, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_rdata", RDATA, 8'h00);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Loopback at full speed.
    xfer(8'hA5, 4'd0, 1'b1, 1'b0, -10, 1'b0, 8'h00, 4'd0);
    @(negedge CLK);
    check("single_done_a5", DONE, 0);

    // MISO tied high, slow clock.
    xfer(8'h00, 4'd3, 1'b0, 1'b1, -10, 1'b0, 8'h00, 4'd3);
    @(negedge CLK);

    // START re-pulse mid transfer with new data must be ignored.
    xfer(8'hC6, 4'd1, 1'b1, 1'b0, 5, 1'b1, 8'h3C, 4'd1);
    stray = 0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) stray++;
    end
    check("no_queued_restart", stray, 0);

    // Back-to-back: START on the DONE cycle.
    xfer(8'h42, 4'd1, 1'b1, 1'b0, -10, 1'b0, 8'h00, 4'd1);
    xfer(8'h81, 4'd1, 1'b1, 1'b0, -10, 1'b0, 8'h00, 4'd1);
    @(negedge CLK);

    // DIV changed mid transfer only affects the next transfer.
    xfer(8'h96, 4'd0, 1'b1, 1'b0, 3, 1'b0, 8'h96, 4'd7);
    @(negedge CLK);
    xfer(8'h69, 4'd7, 1'b1, 1'b0, -10, 1'b0, 8'h00, 4'd7);
    @(negedge CLK);

    // Reset mid transfer.
    xfer(8'h5A, 4'd0, 1'b1, 1'b0, -10, 1'b0, 8'h00, 4'd0);
    @(negedge CLK);
    check("pre_abort_rdata", RDATA, 8'h5A);
    START = 1'b1; WDATA = 8'hE7; DIV = 4'd0;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    check("abort_busy_before", BUSY, 1);
    nRST = 1'b0;
    #1;
    check("abort_sck", SCK, 0);
    check("abort_mosi", MOSI, 1);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_rdata", RDATA, 8'h00);
    last_rd = 8'h00;
    @(negedge CLK);
    nRST = 1'b1;
    START = 1'b1;
    WDATA = 8'hFF;
    @(negedge CLK);
    START = 1'b0;
    check("start_at_release_ignored", BUSY, 0);
    stray = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) stray++;
    end
    check("no_done_after_abort", stray, 0);
    check("rdata_after_abort", RDATA, 8'h00);

    // Normal operation after abort.
    xfer(8'h3C, 4'd0, 1'b1, 1'b0, -10, 1'b0, 8'h00, 4'd0);
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer.md
SPI_XFER -- requirements
Module: spi_xfer

Interface
REQ-001 SHALL have parameter DIVW, default 4, width of the SCK half-period divider field.
REQ-002 SHALL have port CLK, input, 1, the single block clock (Gigatron CLKx4 domain); all state changes on posedge CLK.
REQ-003 SHALL have port nRST, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port START, input, 1, one-cycle transfer request strobe from the extended ctrl-code decoder.
REQ-005 SHALL have port WDATA, input, 8, byte to transmit, MSB first.
REQ-006 SHALL have port DIV, input, DIVW, half-period select: SCK half-period = DIV+1 CLK cycles.
REQ-007 SHALL have port MISO, input, 1, serial data in, already muxed by the selected nSS.
REQ-008 SHALL have port SCK, output, 1, SPI clock, mode 0 (idle low).
REQ-009 SHALL have port MOSI, output, 1, serial data out.
REQ-010 SHALL have port BUSY, output, 1, high while a transfer is in progress.
REQ-011 SHALL have port DONE, output, 1, one-cycle pulse at transfer completion.
REQ-012 SHALL have port RDATA, output, 8, last completed received byte, readable on the Gigatron data bus.

Function
REQ-013 SHALL implement states IDLE and SHIFT; IDLE->SHIFT on START while IDLE; SHIFT->IDLE after the 8th SCK falling edge.
REQ-014 SHALL latch WDATA and DIV on the accepting edge; later changes to WDATA/DIV SHALL not affect the current transfer.
REQ-015 SHALL, at the cycle after acceptance, drive BUSY=1, SCK=0, MOSI=WDATA[7], and load the half-period counter with DIV.
REQ-016 SHALL decrement the counter each cycle in SHIFT; at 0 it SHALL toggle SCK and reload DIV.
REQ-017 SHALL sample MISO into the receive shift register LSB on each SCK rising edge (the cycle SCK goes 0->1).
REQ-018 SHALL present the next MOSI bit on each SCK falling edge for falling edges 1..7.
REQ-019 SHALL, on the 8th falling edge: return SCK to 0, set BUSY=0, pulse DONE=1 for exactly one cycle, load RDATA with the 8 received bits (first sampled bit in RDATA[7]), set MOSI=1.
REQ-020 SHALL complete a transfer with DONE asserted exactly 16*(DIV+1) cycles after BUSY first asserts.
REQ-021 SHALL ignore START while BUSY=1 (no restart, no queueing, no effect on data).
REQ-022 SHALL accept START in the DONE cycle (BUSY=0), giving back-to-back transfers with one idle cycle of SCK=0 minimum.
REQ-023 SHALL hold RDATA unchanged except at REQ-019 completion.
REQ-024 SHALL, in IDLE, hold SCK=0, MOSI=1, BUSY=0, DONE=0.
REQ-025 SHALL use a 4-bit bit counter and modulo-2^DIVW counter arithmetic; DIV=0 gives a half-period of 1 cycle (SCK = CLK/2).

Reset
REQ-026 SHALL, while nRST=0, force SCK=0, MOSI=1, BUSY=0, DONE=0, RDATA=8'h00, state IDLE, counters 0.
REQ-027 SHALL abort any transfer on reset mid-operation without a DONE pulse and without updating RDATA beyond clearing it.
REQ-028 SHALL ignore START asserted in the same cycle nRST deasserts.

Verification
REQ-029 SHALL verify loopback (MISO=MOSI), DIV=0, WDATA=8'hA5 -> DONE 16 cycles after BUSY rises, RDATA=8'hA5, 8 SCK pulses of 1-cycle high.
REQ-030 SHALL verify MISO tied 1, DIV=3, WDATA=8'h00 -> SCK high/low 4 cycles each, MOSI 0 for all bits, DONE at 64 cycles, RDATA=8'hFF.
REQ-031 SHALL verify START re-pulsed at cycle 5 of a DIV=1 transfer with WDATA changed to 8'h3C -> ignored; original byte shifted, one DONE only.
REQ-032 SHALL verify START on the DONE cycle with WDATA=8'h81 -> second transfer begins next cycle, MOSI=1 first bit, second DONE 16*(DIV+1) later.
REQ-033 SHALL verify nRST pulsed low mid-transfer (after 3 bits, RDATA previously 8'h5A) -> SCK=0, MOSI=1, BUSY=0, RDATA=8'h00, no DONE.
REQ-034 SHALL verify DIV changed from 0 to 7 during a transfer -> timing stays at DIV=0 until DONE; next transfer uses 8-cycle half-periods.
